// File: rtl/sine_sweep_ctrl.sv
// Sweep sequencer for a DDS/NCO sine core: loads tone parameters, restarts the
// phase, then steps the tuning word through n_steps+1 points of fixed dwell.
//
// state | meaning
// IDLE  | waiting for a descriptor (cfg_ready=1)
// RUN   | stepping frequency, dwell_cnt counts down the current point
// HOLD  | dwell=0, continuous tone at f_start until abort
// DONE  | one-cycle done pulse, DDS disabled, then IDLE
module sine_sweep_ctrl #(
    parameter int FTW_W = 32,
    parameter int PH_W  = 16,
    parameter int AMP_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [FTW_W-1:0] cfg_f_start,
    input  logic [FTW_W-1:0] cfg_f_step,
    input  logic [CNT_W-1:0] cfg_n_steps,
    input  logic [CNT_W-1:0] cfg_dwell,
    input  logic [PH_W-1:0]  cfg_phase,
    input  logic [AMP_W-1:0] cfg_amp,
    input  logic [AMP_W-1:0] cfg_offset,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] step_idx,
    output logic             dds_en,
    output logic             dds_phase_rst,
    output logic [FTW_W-1:0] dds_ftw,
    output logic [PH_W-1:0]  dds_phase,
    output logic [AMP_W-1:0] dds_amp,
    output logic [AMP_W-1:0] dds_offset
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [FTW_W-1:0] f_step_q;
    logic [CNT_W-1:0] n_steps_q;
    logic [CNT_W-1:0] dwell_q;
    logic [CNT_W-1:0] dwell_cnt;

    assign cfg_ready = (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            f_step_q      <= '0;
            n_steps_q     <= '0;
            dwell_q       <= '0;
            dwell_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            step_idx      <= '0;
            dds_en        <= 1'b0;
            dds_phase_rst <= 1'b0;
            dds_ftw       <= '0;
            dds_phase     <= '0;
            dds_amp       <= '0;
            dds_offset    <= '0;
        end else begin
            dds_phase_rst <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        f_step_q      <= cfg_f_step;
                        n_steps_q     <= cfg_n_steps;
                        dwell_q       <= cfg_dwell;
                        dwell_cnt     <= cfg_dwell - CNT_W'(1);
                        dds_ftw       <= cfg_f_start;
                        dds_phase     <= cfg_phase;
                        dds_amp       <= cfg_amp;
                        dds_offset    <= cfg_offset;
                        dds_en        <= 1'b1;
                        dds_phase_rst <= 1'b1;
                        step_idx      <= '0;
                        busy          <= 1'b1;
                        state         <= (cfg_dwell != '0) ? S_RUN : S_HOLD;
                    end
                end
                S_RUN: begin
                    // abort takes priority even on the final cycle of the last point
                    if (abort) begin
                        aborted <= 1'b1;
                        dds_en  <= 1'b0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else if (dwell_cnt == '0) begin
                        if (step_idx == n_steps_q) begin
                            done   <= 1'b1;
                            dds_en <= 1'b0;
                            busy   <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            dds_ftw   <= dds_ftw + f_step_q;
                            step_idx  <= step_idx + CNT_W'(1);
                            dwell_cnt <= dwell_q - CNT_W'(1);
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        dds_en  <= 1'b0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Directed bench for sine_sweep_ctrl: table of sweep descriptors with
// hand-computed results, plus hold/abort, back-to-back and reset sequences.
module tb_sine_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_f_start;
    logic [31:0] cfg_f_step;
    logic [15:0] cfg_n_steps;
    logic [15:0] cfg_dwell;
    logic [15:0] cfg_phase;
    logic [15:0] cfg_amp;
    logic [15:0] cfg_offset;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] step_idx;
    logic        dds_en;
    logic        dds_phase_rst;
    logic [31:0] dds_ftw;
    logic [15:0] dds_phase;
    logic [15:0] dds_amp;
    logic [15:0] dds_offset;

    int n_checks = 0;
    int n_errors = 0;

    sine_sweep_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_f_start(cfg_f_start), .cfg_f_step(cfg_f_step),
        .cfg_n_steps(cfg_n_steps), .cfg_dwell(cfg_dwell),
        .cfg_phase(cfg_phase), .cfg_amp(cfg_amp), .cfg_offset(cfg_offset),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted),
        .step_idx(step_idx), .dds_en(dds_en), .dds_phase_rst(dds_phase_rst),
        .dds_ftw(dds_ftw), .dds_phase(dds_phase), .dds_amp(dds_amp),
        .dds_offset(dds_offset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f_start;
        logic [31:0] f_step;
        logic [15:0] n_steps;
        logic [15:0] dwell;
        logic [15:0] phase;
        logic [15:0] amp;
        logic [15:0] offset;
        logic [31:0] exp_last_ftw;
        int          exp_busy_cycles;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_ready_timeout"}, 32'(cfg_ready), 32'd1);
    endtask

    task automatic load_desc(input vec_t v);
        cfg_f_start = v.f_start;
        cfg_f_step  = v.f_step;
        cfg_n_steps = v.n_steps;
        cfg_dwell   = v.dwell;
        cfg_phase   = v.phase;
        cfg_amp     = v.amp;
        cfg_offset  = v.offset;
    endtask

    task automatic run_sweep(input vec_t v, input int id);
        logic [31:0] ftw;
        string       tag;
        int          total;
        tag = $sformatf("vec%0d", id);
        wait_ready(tag);
        load_desc(v);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        total = (int'(v.n_steps) + 1) * int'(v.dwell);
        chk({tag, "_busy_cycles"}, 32'(total), 32'(v.exp_busy_cycles));
        ftw = v.f_start;
        for (int c = 0; c < total; c++) begin
            if (c == 0) begin
                chk({tag, "_phase"}, 32'(dds_phase), 32'(v.phase));
                chk({tag, "_amp"}, 32'(dds_amp), 32'(v.amp));
                chk({tag, "_offset"}, 32'(dds_offset), 32'(v.offset));
            end
            chk($sformatf("%s_c%0d_phase_rst", tag, c), 32'(dds_phase_rst), (c == 0) ? 32'd1 : 32'd0);
            chk($sformatf("%s_c%0d_ftw", tag, c), dds_ftw, ftw);
            chk($sformatf("%s_c%0d_idx", tag, c), 32'(step_idx), 32'(c / int'(v.dwell)));
            chk($sformatf("%s_c%0d_en_busy_done_rdy", tag, c),
                {28'd0, dds_en, busy, done, cfg_ready}, 32'b1100);
            tick();
            if ((c + 1) % int'(v.dwell) == 0) ftw = ftw + v.f_step;
        end
        chk({tag, "_done_en_busy"}, {29'd0, done, dds_en, busy}, 32'b100);
        chk({tag, "_last_ftw"}, dds_ftw, v.exp_last_ftw);
        chk({tag, "_done_ready"}, 32'(cfg_ready), 32'd0);
        tick();
        chk({tag, "_after_done"}, {30'd0, done, cfg_ready}, 32'b01);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{100, 10, 3, 4, 16'h1234, 16'h7FFF, 16'h0800, 130, 16};
        vecs[1] = '{5, 7, 0, 1, 16'h0001, 16'h0002, 16'h0003, 5, 1};
        vecs[2] = '{32'hFFFF_FFF0, 32'h20, 1, 2, 16'hFFFF, 16'h00AA, 16'h5555, 32'h10, 4};
        vecs[3] = '{32'h10, 32'hFFFF_FFF0, 1, 3, 16'h0, 16'h1000, 16'h0, 32'h0, 6};
        vecs[4] = '{1000, 32'hFFFF_FF9C, 2, 1, 16'h4000, 16'h0100, 16'hFF00, 800, 3};

        rst_n = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
        load_desc(vecs[0]);
        #12;
        chk("reset_ready", 32'(cfg_ready), 32'd1);
        chk("reset_flags", {26'd0, busy, done, aborted, dds_en, dds_phase_rst, 1'b0}, 32'd0);
        chk("reset_ftw", dds_ftw, 32'd0);
        chk("reset_words", {dds_phase, dds_amp | dds_offset | step_idx}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_sweep(vecs[i], i);

        // HOLD: continuous tone until abort
        v = '{32'h0ABC_0000, 32'h1, 5, 0, 16'h0, 16'h0, 16'h0, 32'h0ABC_0000, 0};
        wait_ready("hold");
        load_desc(v);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("hold_phase_rst", 32'(dds_phase_rst), 32'd1);
        for (int c = 1; c < 50; c++) begin
            tick();
            chk($sformatf("hold_c%0d", c), {dds_ftw[31:4], dds_en, busy, done, dds_phase_rst},
                {v.f_start[31:4], 4'b1100});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("hold_abort_flags", {27'd0, aborted, done, dds_en, busy, cfg_ready}, 32'b10001);
        tick();
        chk("hold_abort_pulse_end", {30'd0, aborted, done}, 32'd0);

        // abort on the last cycle of the last point beats done
        v = '{200, 50, 1, 2, 16'h0, 16'h0, 16'h0, 250, 4};
        load_desc(v);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        repeat (3) tick();
        chk("abort_last_idx", 32'(step_idx), 32'd1);
        chk("abort_last_ftw", dds_ftw, 32'd250);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_last_flags", {28'd0, aborted, done, dds_en, busy}, 32'b1000);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("abort_last_no_done%0d", c), {30'd0, done, aborted}, 32'd0);
        end

        // abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_ignored", {30'd0, aborted, cfg_ready}, 32'b01);

        // cfg_valid held high across a sweep
        v = '{32'h55, 1, 0, 2, 16'h0, 16'h0, 16'h0, 32'h55, 2};
        load_desc(v);
        cfg_valid = 1'b1;
        tick();
        cfg_f_start = 32'h77; cfg_dwell = 16'd1;
        chk("b2b_k1", {dds_ftw[7:0], 22'd0, cfg_ready, dds_phase_rst}, {8'h55, 24'b01});
        tick();
        chk("b2b_k2", {dds_ftw[7:0], 22'd0, cfg_ready, dds_phase_rst}, {8'h55, 24'b00});
        tick();
        chk("b2b_k3_done", {28'd0, done, dds_en, busy, cfg_ready}, 32'b1000);
        tick();
        chk("b2b_k4_idle", {29'd0, dds_en, busy, cfg_ready}, 32'b001);
        tick();
        cfg_valid = 1'b0;
        chk("b2b_k5_second", {dds_ftw[7:0], 21'd0, dds_phase_rst, dds_en, busy}, {8'h77, 24'b111});
        tick();
        chk("b2b_k6_done", 32'(done), 32'd1);
        tick();

        // asynchronous reset mid-RUN
        wait_ready("rst");
        load_desc(vecs[0]);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        repeat (8) tick();
        chk("rst_mid_idx", 32'(step_idx), 32'd2);
        chk("rst_mid_ftw", dds_ftw, 32'd120);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(cfg_ready), 32'd1);
        chk("rst_mid_flags", {26'd0, busy, done, aborted, dds_en, dds_phase_rst, 1'b0}, 32'd0);
        chk("rst_mid_ftw0", dds_ftw, 32'd0);
        chk("rst_mid_words", {dds_phase, dds_amp | dds_offset | step_idx}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rst_release_quiet", {29'd0, done, aborted, cfg_ready}, 32'b001);
        run_sweep(vecs[0], 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
